// File: rtl/data_mem_port.sv
// data_mem_port: data-memory access unit between execute and the data bus.
//   Turns one load/store control op into one bus transaction, stalling the
//   core until busAck (or a timeout) ends it.
// Ports:
//   clk, nRST                      clock / async active-low reset
//   cuOP[5:0]                      control-unit op (CU_* codes below)
//   memAddr, storeData             effective address / store value
//   busRdata, busAck               bus read data, 1-cycle completion strobe
//   busAddr, busWdata, busByteEn   word address, lane-replicated data, enables
//   busRead, busWrite              registered request strobes, high in REQ
//   memload                        right-justified, zero-filled load data
//   memStall                       core stall
//   busError                       1-cycle timeout / misalign flag (in DONE)
// Optional macro: MISALIGN_CHECK_EN -- misaligned half/word ops skip the bus
//   and go straight to DONE with busError set.
module data_mem_port #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [5:0]  cuOP,
  input  logic [31:0] memAddr,
  input  logic [31:0] storeData,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busByteEn,
  output logic        busRead,
  output logic        busWrite,
  output logic [31:0] memload,
  output logic        memStall,
  output logic        busError
);

  localparam logic [5:0] CU_LB  = 6'h10;
  localparam logic [5:0] CU_LH  = 6'h11;
  localparam logic [5:0] CU_LW  = 6'h12;
  localparam logic [5:0] CU_LBU = 6'h13;
  localparam logic [5:0] CU_LHU = 6'h14;
  localparam logic [5:0] CU_SB  = 6'h18;
  localparam logic [5:0] CU_SH  = 6'h19;
  localparam logic [5:0] CU_SW  = 6'h1A;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic [1:0]  sz_q, sz_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] load_q, load_d;

  // op decode
  logic        op_mem, op_ld, misal;
  logic [1:0]  op_sz;
  logic [1:0]  off;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  assign off = memAddr[1:0];

  always_comb begin
    op_mem = 1'b1;
    op_ld  = 1'b0;
    op_sz  = SZ_W;
    case (cuOP)
      CU_LB, CU_LBU: begin op_ld = 1'b1; op_sz = SZ_B; end
      CU_LH, CU_LHU: begin op_ld = 1'b1; op_sz = SZ_H; end
      CU_LW:         begin op_ld = 1'b1; op_sz = SZ_W; end
      CU_SB:         op_sz = SZ_B;
      CU_SH:         op_sz = SZ_H;
      CU_SW:         op_sz = SZ_W;
      default:       op_mem = 1'b0;
    endcase
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = storeData;
    case (op_sz)
      SZ_B: begin
        be_new    = 4'b0001 << off;
        wdata_new = {4{storeData[7:0]}};
      end
      SZ_H: begin
        be_new    = 4'b0011 << {off[1], 1'b0};
        wdata_new = {2{storeData[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  assign misal = ((op_sz == SZ_H) && off[0]) || ((op_sz == SZ_W) && (off != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Right-justify the addressed lane of the returned word, zero above it.
  logic [4:0]  rsh_amt;
  logic [31:0] rsh, load_new;

  always_comb begin
    rsh_amt  = 5'd0;
    if (sz_q == SZ_B)      rsh_amt = {off_q, 3'b000};
    else if (sz_q == SZ_H) rsh_amt = {off_q[1], 4'b0000};
    rsh      = busRdata >> rsh_amt;
    load_new = rsh;
    if (sz_q == SZ_B)      load_new = {24'h0, rsh[7:0]};
    else if (sz_q == SZ_H) load_new = {16'h0, rsh[15:0]};
  end

  logic stall_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    sz_d    = sz_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    load_d  = load_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = op_mem;
        if (op_mem) begin
          ld_d    = op_ld;
          sz_d    = op_sz;
          off_d   = off;
          addr_d  = {memAddr[31:2], 2'b00};
          wdata_d = wdata_new;
          be_d    = be_new;
          cnt_d   = '0;
          if (misal) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            rd_d    = op_ld;
            wr_d    = ~op_ld;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // ack has priority over a timeout on the same edge
        if (busAck) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (ld_q) load_d = load_new;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      sz_q    <= SZ_B;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      sz_q    <= sz_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  assign busAddr   = addr_q;
  assign busWdata  = wdata_q;
  assign busByteEn = be_q;
  assign busRead   = rd_q;
  assign busWrite  = wr_q;
  assign busError  = err_q;
  assign memload   = load_q;
  // stall is combinational from cuOP in IDLE; keep it low while in reset
  assign memStall  = stall_c & nRST;

endmodule
